// File: rtl/candy_pkg.sv
// Shared types and constants for the candy dispenser controller.
package candy_pkg;

  // Width of the Pi amount code and the largest portion count it can select
  localparam int AMT_W        = 2;
  localparam int MAX_PORTIONS = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    STEP_HI = 3'd2,
    STEP_LO = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Amount code 00 selects one portion, 11 selects four
  function automatic int portions_of(input logic [AMT_W-1:0] code);
    return int'(code) + 1;
  endfunction

endpackage

// File: rtl/candy_dispense_ctrl_if.sv
// Pi request / stepper driver signal bundle for the dispenser controller.
interface candy_dispense_ctrl_if;
  import candy_pkg::*;

  logic             candyflag;
  logic [AMT_W-1:0] stateamount;
  logic             stepper_step;
  logic             stepper_dir;
  logic             handshake;
  logic             busy;

  // Pi side: raises requests, watches the acknowledge
  modport master (
    output candyflag, stateamount,
    input  stepper_step, stepper_dir, handshake, busy
  );

  // Controller side
  modport slave (
    input  candyflag, stateamount,
    output stepper_step, stepper_dir, handshake, busy
  );
endinterface

// File: rtl/pi_input_sync.sv
// Multi-flop synchronizer for asynchronous Pi GPIO inputs, with a rising-edge
// strobe on bit 0. The edge prev-flop resets to 0 so a line already high at
// reset release counts as a fresh edge.
module pi_input_sync #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_x1,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic             rise_o
);
  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic             prev_q;

  // Shift the raw inputs through the synchronizer chain and remember bit 0
  always_ff @(posedge clk_x1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      prev_q <= 1'b0;
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[SYNC_STAGES-1][0];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];
  assign rise_o = sync_o[0] & ~prev_q;
endmodule

// File: rtl/candy_dispense_ctrl.sv
// Candy dispenser controller: turns a Pi request (candyflag + amount code)
// into a burst of 50%-duty stepper pulses and acknowledges completion.
module candy_dispense_ctrl #(
  parameter int   SYNC_STAGES       = 2,
  parameter int   STEP_DIV          = 6000,
  parameter int   STEPS_PER_PORTION = 200,
  parameter int   HS_MIN_CYCLES     = 16,
  parameter logic DIR_FWD           = 1'b1
) (
  input  logic                  clk_x1,
  input  logic                  rst,
  candy_dispense_ctrl_if.slave  bus
);
  import candy_pkg::*;

  localparam int HALF   = STEP_DIV / 2;
  localparam int STEP_W = $clog2(MAX_PORTIONS * STEPS_PER_PORTION + 1);
  localparam int PH_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int HS_W   = $clog2(HS_MIN_CYCLES + 1);

  logic [AMT_W:0]   sync_vec;
  logic             flag_sync;
  logic [AMT_W-1:0] amt_sync;
  logic             req_rise;
  logic [STEP_W-1:0] total_steps;

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [HS_W-1:0]   hs_q, hs_d;

  pi_input_sync #(
    .WIDTH       (AMT_W + 1),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_x1  (clk_x1),
    .rst     (rst),
    .async_i ({bus.stateamount, bus.candyflag}),
    .sync_o  (sync_vec),
    .rise_o  (req_rise)
  );

  assign flag_sync   = sync_vec[0];
  assign amt_sync    = sync_vec[AMT_W:1];
  assign total_steps = STEP_W'(portions_of(amt_sync) * STEPS_PER_PORTION);

  // State and counter registers
  always_ff @(posedge clk_x1 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      hs_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      hs_q    <= hs_d;
    end
  end

  // Next-state: accept a request, pace the half periods, count pulses, hold the ack
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    hs_d    = hs_q;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        hs_d    = '0;
        if (req_rise) begin
          cnt_d   = total_steps;
          state_d = ARM;
        end
      end
      ARM: begin
        phase_d = '0;
        state_d = STEP_HI;
      end
      STEP_HI: begin
        if (phase_q == PH_W'(HALF - 1)) begin
          phase_d = '0;
          state_d = STEP_LO;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      STEP_LO: begin
        if (phase_q == PH_W'(HALF - 1)) begin
          phase_d = '0;
          cnt_d   = cnt_q - STEP_W'(1);
          hs_d    = '0;
          state_d = (cnt_q == STEP_W'(1)) ? DONE : STEP_HI;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      DONE: begin
        // Saturating count of cycles spent acknowledging
        if (hs_q != HS_W'(HS_MIN_CYCLES)) hs_d = hs_q + HS_W'(1);
        if (!flag_sync && (hs_q >= HS_W'(HS_MIN_CYCLES - 1))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.stepper_step = (state_q == STEP_HI);
  assign bus.stepper_dir  = (state_q != IDLE) ? DIR_FWD : 1'b0;
  assign bus.handshake    = (state_q == DONE);
  assign bus.busy         = (state_q != IDLE);
endmodule
